frogger_player_fsm: RTL
=======================

// Module: frogger_player_fsm
// PURPOSE
//  Parametrised frog controller: grid position, lives, score and round state.
//  Sits between the button edge inputs and the renderer/collision logic.
//  Adds a lives counter, a respawn delay, water death and game-over to the basic frog mover.
//  Grid size, start cell, lives and timing are generic.
// PARAMETERS
//  GRID_W        20        grid columns; X range 0..GRID_W-1
//  GRID_H        15        grid rows; Y range 0..GRID_H-1, row 0 = home row
//  START_X       10        respawn column
//  START_Y       14        respawn row (must equal GRID_H-1)
//  LIVES         3         lives at reset (1..7)
//  SCORE_W       7         score width; score saturates at 2^SCORE_W-1
//  RESPAWN_TICKS 25000000  clocks spent in DYING before respawn (>=1)
//  DRIFT_TICKS   39000000  clocks per one-cell log drift (LOG_DRIFT_EN only)
//  TILE_HOME     4         i_Tile code for a home slot
//  TILE_WATER    2         i_Tile code for water
// PORTS
//  i_Clk         in   1        system clock
//  i_Reset       in   1        synchronous, active-high reset
//  i_Up_Mvt      in   1        up button level (debounced upstream)
//  i_Down_Mvt    in   1        down button level
//  i_Left_Mvt    in   1        left button level
//  i_Right_Mvt   in   1        right button level
//  i_Collided    in   1        frog overlaps a car this cycle
//  i_Tile        in   4        tile code under the frog's current cell
//  i_On_Log      in   1        frog cell is covered by a log
//  o_Frogger_X   out  6        frog column
//  o_Frogger_Y   out  6        frog row
//  o_Score       out  SCORE_W  homes reached
//  o_Lives       out  3        remaining lives
//  o_State       out  2        00 PLAY, 01 DYING, 10 SCORED, 11 OVER
//  o_Game_Over   out  1        high while the state is OVER
// BEHAVIOUR
//  - One clock; reset is synchronous, active-high on i_Reset.
//  - Reset values: X=START_X, Y=START_Y, score=0, lives=LIVES, state=PLAY, o_Game_Over=0.
//    All edge registers clear to 0. The drift and respawn counters clear to 0.
//  - Moves are rising-edge detected per button against a 1-cycle delayed copy.
//    Only one move is applied per cycle, in priority Up > Down > Left > Right.
//    A move into the grid edge is ignored; there is no wrap on button moves.
//    Position updates 1 cycle after the edge cycle.
//  - In PLAY, events are evaluated in the following order of priority:
//    1. Death (i_Collided, or i_Tile==TILE_WATER && !i_On_Log).
//       lives-1; state goes to DYING if lives>1, else to OVER with lives=0.
//    2. Y==0 && i_Tile==TILE_HOME: score+1 (saturating); state goes to SCORED.
//    3. Y==0 && i_Tile!=TILE_HOME: treated as a death (same as item 1).
//    4. Otherwise a button move or a drift step is applied.
//  - DYING: buttons are ignored and position is held.
//    After RESPAWN_TICKS clocks, X/Y are set to START and the state returns to PLAY.
//  - SCORED: lasts exactly 1 cycle. X/Y are set to START and the state goes to PLAY.
//  - OVER: everything is held until i_Reset. o_Game_Over=1.
//  - Edge registers update in every state, so a button held across a respawn
//    does not produce a move.
//  - Reset asserted mid-DYING or mid-drift aborts immediately and applies the reset values.
// CONFIGURATION
//  LOG_DRIFT_EN defined:
//  - While PLAY && i_On_Log, the drift counter increments.
//  - At DRIFT_TICKS-1 the counter clears and X decrements. At X==0, X wraps to GRID_W-1.
//  - A Left/Right move in the same cycle wins and clears the counter.
//  - The counter clears whenever !i_On_Log or state!=PLAY.
//  LOG_DRIFT_EN undefined: there is no drift counter and X changes only on buttons.
//  The water-death rule applies in both builds.
// TESTING
//  Run the bench with DRIFT_TICKS=4 and RESPAWN_TICKS=3.
//  - Reset, then pulse Up 3 times -> Y=11, X=10, state PLAY.
//  - Up and Right rising in the same cycle -> only Y-1 is applied; X is unchanged.
//  - At X=19, pulse Right -> X stays 19. At Y=14, pulse Down -> Y stays 14.
//  - Collide at lives=3 -> lives=2, state DYING for 3 clocks, then X=10/Y=14 and PLAY.
//    The third death gives lives=0, OVER, o_Game_Over=1; buttons are then ignored.
//  - Reach Y=0 with i_Tile=4 -> score 0->1, SCORED for 1 cycle, respawn at (10,14).
//    With i_Tile=1 instead -> a life is lost.
//  - LOG_DRIFT_EN, on log at X=0 for 4 clocks -> X=19.
//    Without the macro, X stays 0. Water with i_On_Log=0 -> death in both builds.

Source files
------------

// File: rtl/frogger_player_fsm.sv
// Frog controller: grid position, lives, score and PLAY/DYING/SCORED/OVER round state.
// Define LOG_DRIFT_EN to make a frog riding a log drift one cell left every DRIFT_TICKS clocks.
module frogger_player_fsm #(
    parameter int unsigned GRID_W        = 20,
    parameter int unsigned GRID_H        = 15,
    parameter int unsigned START_X       = 10,
    parameter int unsigned START_Y       = 14,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned SCORE_W       = 7,
    parameter int unsigned RESPAWN_TICKS = 25000000,
    parameter int unsigned DRIFT_TICKS   = 39000000,
    parameter int unsigned TILE_HOME     = 4,
    parameter int unsigned TILE_WATER    = 2
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Up_Mvt,
    input  logic               i_Down_Mvt,
    input  logic               i_Left_Mvt,
    input  logic               i_Right_Mvt,
    input  logic               i_Collided,
    input  logic [3:0]         i_Tile,
    input  logic               i_On_Log,
    output logic [5:0]         o_Frogger_X,
    output logic [5:0]         o_Frogger_Y,
    output logic [SCORE_W-1:0] o_Score,
    output logic [2:0]         o_Lives,
    output logic [1:0]         o_State,
    output logic               o_Game_Over
);

    localparam int unsigned RESP_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

    typedef enum logic [1:0] {
        PLAY   = 2'b00,
        DYING  = 2'b01,
        SCORED = 2'b10,
        OVER   = 2'b11
    } state_t;

    state_t              state_q;
    logic [5:0]          x_q;
    logic [5:0]          y_q;
    logic [SCORE_W-1:0]  score_q;
    logic [2:0]          lives_q;
    logic                game_over_q;
    logic [RESP_W-1:0]   resp_q;
    logic                up_q;
    logic                down_q;
    logic                left_q;
    logic                right_q;

    logic                up_edge_c;
    logic                down_edge_c;
    logic                left_edge_c;
    logic                right_edge_c;
    logic                hazard_c;
    logic                kill_c;
    logic                score_c;
    logic [5:0]          x_mv_c;
    logic [5:0]          y_mv_c;
    logic [5:0]          x_play_c;

    assign up_edge_c    = i_Up_Mvt    & ~up_q;
    assign down_edge_c  = i_Down_Mvt  & ~down_q;
    assign left_edge_c  = i_Left_Mvt  & ~left_q;
    assign right_edge_c = i_Right_Mvt & ~right_q;

    // Death outranks scoring; reaching the home row without a home slot is also fatal.
    assign hazard_c = i_Collided | ((i_Tile == 4'(TILE_WATER)) & ~i_On_Log);
    assign kill_c   = hazard_c | ((y_q == 6'd0) & (i_Tile != 4'(TILE_HOME)));
    assign score_c  = ~hazard_c & (y_q == 6'd0) & (i_Tile == 4'(TILE_HOME));

    // Highest-priority rising edge selects the move; a blocked move is simply dropped.
    always_comb begin
        x_mv_c = x_q;
        y_mv_c = y_q;
        if (up_edge_c) begin
            if (y_q != 6'd0) y_mv_c = y_q - 6'd1;
        end else if (down_edge_c) begin
            if (y_q != 6'(GRID_H - 1)) y_mv_c = y_q + 6'd1;
        end else if (left_edge_c) begin
            if (x_q != 6'd0) x_mv_c = x_q - 6'd1;
        end else if (right_edge_c) begin
            if (x_q != 6'(GRID_W - 1)) x_mv_c = x_q + 6'd1;
        end
    end

`ifdef LOG_DRIFT_EN
    localparam int unsigned DRIFT_W = (DRIFT_TICKS > 1) ? $clog2(DRIFT_TICKS) : 1;

    logic [DRIFT_W-1:0] drift_q;
    logic               lr_move_c;
    logic               drift_step_c;

    assign lr_move_c    = ~up_edge_c & ~down_edge_c & (left_edge_c | right_edge_c);
    assign drift_step_c = i_On_Log & ~lr_move_c & (drift_q == DRIFT_W'(DRIFT_TICKS - 1));

    always_comb begin
        x_play_c = x_mv_c;
        if (drift_step_c) begin
            x_play_c = (x_q == 6'd0) ? 6'(GRID_W - 1) : x_q - 6'd1;
        end
    end

    // Drift counter only runs while the frog is alive, in play and riding a log.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            drift_q <= '0;
        end else if ((state_q != PLAY) || !i_On_Log || kill_c || score_c ||
                     lr_move_c || drift_step_c) begin
            drift_q <= '0;
        end else begin
            drift_q <= drift_q + DRIFT_W'(1);
        end
    end
`else
    logic [31:0] unused_drift_c;

    assign unused_drift_c = 32'(DRIFT_TICKS);
    assign x_play_c       = x_mv_c;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= PLAY;
            x_q         <= 6'(START_X);
            y_q         <= 6'(START_Y);
            score_q     <= '0;
            lives_q     <= 3'(LIVES);
            game_over_q <= 1'b0;
            resp_q      <= '0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
        end else begin
            // Edge history tracks buttons in every state so a held button never re-fires.
            up_q    <= i_Up_Mvt;
            down_q  <= i_Down_Mvt;
            left_q  <= i_Left_Mvt;
            right_q <= i_Right_Mvt;

            case (state_q)
                PLAY: begin
                    if (kill_c) begin
                        resp_q <= '0;
                        if (lives_q > 3'd1) begin
                            lives_q <= lives_q - 3'd1;
                            state_q <= DYING;
                        end else begin
                            lives_q     <= 3'd0;
                            state_q     <= OVER;
                            game_over_q <= 1'b1;
                        end
                    end else if (score_c) begin
                        if (score_q != {SCORE_W{1'b1}}) score_q <= score_q + SCORE_W'(1);
                        state_q <= SCORED;
                    end else begin
                        x_q <= x_play_c;
                        y_q <= y_mv_c;
                    end
                end
                DYING: begin
                    if (resp_q == RESP_W'(RESPAWN_TICKS - 1)) begin
                        resp_q  <= '0;
                        x_q     <= 6'(START_X);
                        y_q     <= 6'(START_Y);
                        state_q <= PLAY;
                    end else begin
                        resp_q <= resp_q + RESP_W'(1);
                    end
                end
                SCORED: begin
                    x_q     <= 6'(START_X);
                    y_q     <= 6'(START_Y);
                    state_q <= PLAY;
                end
                OVER: begin
                    game_over_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_Frogger_X = x_q;
    assign o_Frogger_Y = y_q;
    assign o_Score     = score_q;
    assign o_Lives     = lives_q;
    assign o_State     = state_q;
    assign o_Game_Over = game_over_q;

endmodule
